// File: rtl/alu_wb.sv
// alu_wb: in-order writeback buffer between the ALU and the register file.
// Ports: clk/rst_n; in_* push side (in_valid/in_ready, result, carry,
//   overflow, select, dest); wb_* pop side (wb_valid/wb_ready, wb_addr,
//   wb_data); flags {N,Z,C,V} committed on each pop.
// Parameter DEPTH (2, 4 or 8) sets the number of buffered entries.
// Optional macro STICKY_OVF_EN adds clr_sticky / sticky_v, a sticky
//   record of any committed arithmetic overflow.
module alu_wb #(
  parameter int DEPTH = 2
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        in_valid,
  output logic        in_ready,
  input  logic [15:0] in_result,
  input  logic        in_carry,
  input  logic        in_overflow,
  input  logic        in_select,
  input  logic [2:0]  in_dest,
  output logic        wb_valid,
  input  logic        wb_ready,
  output logic [2:0]  wb_addr,
  output logic [15:0] wb_data,
  output logic [3:0]  flags
`ifdef STICKY_OVF_EN
  ,
  input  logic        clr_sticky,
  output logic        sticky_v
`endif
);

  localparam int AW = $clog2(DEPTH);
  localparam int CW = AW + 1;

  // Entry storage; never read while empty, so it carries no reset.
  logic [15:0] r_res [DEPTH];
  logic        r_cy  [DEPTH];
  logic        r_ov  [DEPTH];
  logic        r_sel [DEPTH];
  logic [2:0]  r_dst [DEPTH];

  logic [AW-1:0] r_wptr;
  logic [AW-1:0] r_rptr;
  logic [CW-1:0] r_count;
  logic [3:0]    r_flags;

  logic          w_push;
  logic          w_pop;
  logic          w_empty;
  logic [15:0]   w_hres;
  logic          w_hcy;
  logic          w_hov;
  logic          w_hsel;
  logic [2:0]    w_hdst;
  logic [3:0]    w_nflags;

  assign w_empty  = (r_count == '0);
  assign in_ready = (r_count < CW'(DEPTH));
  assign wb_valid = !w_empty;
  assign w_push   = in_valid && in_ready;
  assign w_pop    = wb_valid && wb_ready;

  assign w_hres = r_res[r_rptr];
  assign w_hcy  = r_cy[r_rptr];
  assign w_hov  = r_ov[r_rptr];
  assign w_hsel = r_sel[r_rptr];
  assign w_hdst = r_dst[r_rptr];

  // Empty buffer reads as zero rather than exposing stale storage.
  assign wb_data = w_empty ? 16'h0000 : w_hres;
  assign wb_addr = w_empty ? 3'd0 : w_hdst;
  assign flags   = r_flags;

  always_ff @(posedge clk) begin
    if (w_push) begin
      r_res[r_wptr] <= in_result;
      r_cy[r_wptr]  <= in_carry;
      r_ov[r_wptr]  <= in_overflow;
      r_sel[r_wptr] <= in_select;
      r_dst[r_wptr] <= in_dest;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_wptr <= '0;
    end else if (w_push) begin
      r_wptr <= r_wptr + AW'(1);
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_rptr <= '0;
    end else if (w_pop) begin
      r_rptr <= r_rptr + AW'(1);
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_count <= '0;
    end else begin
      unique case ({w_push, w_pop})
        2'b10:   r_count <= r_count + CW'(1);
        2'b01:   r_count <= r_count - CW'(1);
        default: r_count <= r_count;
      endcase
    end
  end

  // Logic-unit results leave C and V untouched.
  always_comb begin
    w_nflags    = r_flags;
    w_nflags[3] = w_hres[15];
    w_nflags[2] = (w_hres == 16'h0000);
    if (!w_hsel) begin
      w_nflags[1] = w_hcy;
      w_nflags[0] = w_hov;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_flags <= '0;
    end else if (w_pop) begin
      r_flags <= w_nflags;
    end
  end

`ifdef STICKY_OVF_EN
  logic r_sticky;
  logic w_sset;

  assign w_sset   = w_pop && !w_hsel && w_hov;
  assign sticky_v = r_sticky;

  // A new overflow outranks a clear in the same cycle.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_sticky <= 1'b0;
    end else if (w_sset) begin
      r_sticky <= 1'b1;
    end else if (clr_sticky) begin
      r_sticky <= 1'b0;
    end
  end
`endif

endmodule

// File: tb/tb_alu_wb.sv
// tb_alu_wb: directed bench for alu_wb, DEPTH=2 and DEPTH=4 side by side,
// checked every cycle against a shift-array model plus literal checks.
module tb_alu_wb;

  typedef struct packed {
    logic [15:0] r;
    logic        c;
    logic        v;
    logic        s;
    logic [2:0]  d;
  } ent_t;

  logic        clk;
  logic        rst_n;
  logic        in_valid;
  logic [15:0] in_result;
  logic        in_carry;
  logic        in_overflow;
  logic        in_select;
  logic [2:0]  in_dest;
  logic        wb_ready;
  logic        clr_sticky;

  logic        o_ir [2];
  logic        o_wv [2];
  logic [2:0]  o_wa [2];
  logic [15:0] o_wd [2];
  logic [3:0]  o_fl [2];
  logic        o_sv [2];

  int n_pass = 0;
  int n_tot  = 0;
  bit chk_on = 1'b1;

  alu_wb #(.DEPTH(2)) u_d2 (
    .clk(clk), .rst_n(rst_n),
    .in_valid(in_valid), .in_ready(o_ir[0]),
    .in_result(in_result), .in_carry(in_carry),
    .in_overflow(in_overflow), .in_select(in_select),
    .in_dest(in_dest),
    .wb_valid(o_wv[0]), .wb_ready(wb_ready),
    .wb_addr(o_wa[0]), .wb_data(o_wd[0]),
    .flags(o_fl[0])
`ifdef STICKY_OVF_EN
    , .clr_sticky(clr_sticky), .sticky_v(o_sv[0])
`endif
  );

  alu_wb #(.DEPTH(4)) u_d4 (
    .clk(clk), .rst_n(rst_n),
    .in_valid(in_valid), .in_ready(o_ir[1]),
    .in_result(in_result), .in_carry(in_carry),
    .in_overflow(in_overflow), .in_select(in_select),
    .in_dest(in_dest),
    .wb_valid(o_wv[1]), .wb_ready(wb_ready),
    .wb_addr(o_wa[1]), .wb_data(o_wd[1]),
    .flags(o_fl[1])
`ifdef STICKY_OVF_EN
    , .clr_sticky(clr_sticky), .sticky_v(o_sv[1])
`endif
  );

`ifndef STICKY_OVF_EN
  assign o_sv[0] = 1'b0;
  assign o_sv[1] = 1'b0;
`endif

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Model: mm[k][0] is the head; a pop shifts the array down.
  ent_t mm [2][8];
  int   mc [2];
  logic [3:0] mf [2];
  logic ms [2];

  function automatic int dep(input int k);
    return (k == 0) ? 2 : 4;
  endfunction

  always @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int k = 0; k < 2; k++) begin
        mc[k] = 0;
        mf[k] = 4'b0000;
        ms[k] = 1'b0;
      end
    end else begin
      for (int k = 0; k < 2; k++) begin
        bit   pu;
        bit   po;
        ent_t h;
        pu = in_valid && (mc[k] < dep(k));
        po = (mc[k] > 0) && wb_ready;
        if (po) begin
          h = mm[k][0];
          mf[k][3] = h.r[15];
          mf[k][2] = (h.r == 16'h0000);
          if (!h.s) begin
            mf[k][1] = h.c;
            mf[k][0] = h.v;
          end
          if (!h.s && h.v) ms[k] = 1'b1;
          else if (clr_sticky) ms[k] = 1'b0;
          for (int j = 0; j < 7; j++) mm[k][j] = mm[k][j+1];
          mc[k] = mc[k] - 1;
        end else if (clr_sticky) begin
          ms[k] = 1'b0;
        end
        if (pu) begin
          mm[k][mc[k]] = '{r: in_result, c: in_carry,
                           v: in_overflow, s: in_select,
                           d: in_dest};
          mc[k] = mc[k] + 1;
        end
      end
    end
  end

  task automatic chk(input string nm, input logic [31:0] a,
                     input logic [31:0] e);
    n_tot++;
    if (a === e) n_pass++;
    else $display("FAIL %s: got %0h expected %0h at %0t", nm, a, e, $time);
  endtask

  always @(negedge clk) begin
    if (chk_on) begin
      for (int k = 0; k < 2; k++) begin
        logic [15:0] ed;
        logic [2:0]  ea;
        ed = (mc[k] > 0) ? mm[k][0].r : 16'h0000;
        ea = (mc[k] > 0) ? mm[k][0].d : 3'd0;
        chk($sformatf("in_ready[%0d]", k), 32'(o_ir[k]),
            32'(mc[k] < dep(k)));
        chk($sformatf("wb_valid[%0d]", k), 32'(o_wv[k]),
            32'(mc[k] > 0));
        chk($sformatf("wb_addr[%0d]", k), 32'(o_wa[k]), 32'(ea));
        chk($sformatf("wb_data[%0d]", k), 32'(o_wd[k]), 32'(ed));
        chk($sformatf("flags[%0d]", k), 32'(o_fl[k]), 32'(mf[k]));
`ifdef STICKY_OVF_EN
        chk($sformatf("sticky_v[%0d]", k), 32'(o_sv[k]), 32'(ms[k]));
`endif
      end
    end
  end

  task automatic drive(input logic v, input logic [15:0] r,
                       input logic c, input logic o,
                       input logic s, input logic [2:0] d);
    in_valid    = v;
    in_result   = r;
    in_carry    = c;
    in_overflow = o;
    in_select   = s;
    in_dest     = d;
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic drain();
    int n;
    in_valid = 1'b0;
    wb_ready = 1'b1;
    n = 0;
    while ((o_wv[0] || o_wv[1]) && n < 20) begin
      tick();
      n++;
    end
    chk("drain", 32'(o_wv[0] || o_wv[1]), 32'd0);
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    rst_n      = 1'b0;
    wb_ready   = 1'b0;
    clr_sticky = 1'b0;
    drive(1'b0, 16'h0, 1'b0, 1'b0, 1'b0, 3'd0);
    #3;
    chk("rst in_ready", 32'(o_ir[0]), 32'd1);
    chk("rst wb_valid", 32'(o_wv[0]), 32'd0);
    chk("rst wb_addr", 32'(o_wa[0]), 32'd0);
    chk("rst wb_data", 32'(o_wd[0]), 32'd0);
    chk("rst flags", 32'(o_fl[0]), 32'd0);
    tick();
    rst_n = 1'b1;
    tick();

    // Zero result with carry: flags 0110.
    wb_ready = 1'b1;
    drive(1'b1, 16'h0000, 1'b1, 1'b0, 1'b0, 3'd3);
    tick();
    drive(1'b0, 16'h0, 1'b0, 1'b0, 1'b0, 3'd0);
    chk("lat wb_valid", 32'(o_wv[0]), 32'd1);
    chk("lat wb_addr", 32'(o_wa[0]), 32'd3);
    chk("lat wb_data", 32'(o_wd[0]), 32'd0);
    chk("lat flags pre-pop", 32'(o_fl[0]), 32'd0);
    tick();
    chk("flags zero-carry", 32'(o_fl[0]), 32'b0110);
    chk("empty after pop", 32'(o_wv[1]), 32'd0);

    // Logic result keeps C and V.
    drive(1'b1, 16'h8000, 1'b0, 1'b1, 1'b1, 3'd5);
    tick();
    drive(1'b0, 16'h0, 1'b0, 1'b0, 1'b0, 3'd0);
    tick();
    chk("flags logic", 32'(o_fl[0]), 32'b1010);
    chk("flags logic d4", 32'(o_fl[1]), 32'b1010);

    // Back-pressure on the DEPTH=2 instance.
    wb_ready = 1'b0;
    drive(1'b1, 16'h1111, 1'b0, 1'b0, 1'b0, 3'd1);
    tick();
    chk("one in ready", 32'(o_ir[0]), 32'd1);
    drive(1'b1, 16'h2222, 1'b1, 1'b0, 1'b0, 3'd2);
    tick();
    chk("full ready", 32'(o_ir[0]), 32'd0);
    drive(1'b1, 16'h3333, 1'b0, 1'b1, 1'b0, 3'd4);
    tick();
    chk("held ready", 32'(o_ir[0]), 32'd0);
    chk("held head", 32'(o_wd[0]), 32'h1111);
    wb_ready = 1'b1;
    tick();
    chk("drain1 data", 32'(o_wd[0]), 32'h2222);
    chk("drain1 ready", 32'(o_ir[0]), 32'd1);
    chk("drain1 flags", 32'(o_fl[0]), 32'b0000);
    tick();
    drive(1'b0, 16'h0, 1'b0, 1'b0, 1'b0, 3'd0);
    chk("entry3 data", 32'(o_wd[0]), 32'h3333);
    chk("entry3 addr", 32'(o_wa[0]), 32'd4);
    chk("drain2 flags", 32'(o_fl[0]), 32'b0010);
    drain();

    // Streaming: pointers wrap, one entry in flight.
    for (int i = 0; i < 10; i++) begin
      drive(1'b1, 16'h0100 + 16'(i), 1'(i), 1'b0, 1'b0, 3'(i));
      tick();
      chk("stream d2", 32'(o_wd[0]), 32'h0100 + 32'(i));
      chk("stream d4", 32'(o_wd[1]), 32'h0100 + 32'(i));
      chk("stream ready", 32'(o_ir[1]), 32'd1);
    end
    drive(1'b0, 16'h0, 1'b0, 1'b0, 1'b0, 3'd0);
    drain();

`ifdef STICKY_OVF_EN
    drive(1'b1, 16'h7fff, 1'b0, 1'b1, 1'b0, 3'd1);
    tick();
    drive(1'b1, 16'h0001, 1'b0, 1'b0, 1'b0, 3'd2);
    tick();
    chk("sticky set", 32'(o_sv[0]), 32'd1);
    drive(1'b1, 16'h4000, 1'b0, 1'b1, 1'b0, 3'd3);
    tick();
    drive(1'b0, 16'h0, 1'b0, 1'b0, 1'b0, 3'd0);
    chk("sticky persist", 32'(o_sv[0]), 32'd1);
    clr_sticky = 1'b1;
    tick();
    chk("sticky set wins", 32'(o_sv[0]), 32'd1);
    tick();
    clr_sticky = 1'b0;
    chk("sticky clear", 32'(o_sv[0]), 32'd0);
`endif

    // Reset with stale entries in the buffer.
    wb_ready = 1'b0;
    drive(1'b1, 16'hbeef, 1'b1, 1'b1, 1'b0, 3'd6);
    tick();
    drive(1'b1, 16'hcafe, 1'b0, 1'b0, 1'b0, 3'd7);
    tick();
    drive(1'b0, 16'h0, 1'b0, 1'b0, 1'b0, 3'd0);
    chk("prefill valid", 32'(o_wv[0]), 32'd1);
    rst_n = 1'b0;
    #1;
    chk("mid rst wb_valid", 32'(o_wv[0]), 32'd0);
    chk("mid rst flags", 32'(o_fl[0]), 32'd0);
    chk("mid rst ready", 32'(o_ir[0]), 32'd1);
    chk("mid rst data d4", 32'(o_wd[1]), 32'd0);
    tick();
    rst_n = 1'b1;
    wb_ready = 1'b1;
    for (int i = 0; i < 4; i++) begin
      tick();
      chk("no stale wb", 32'(o_wv[0] || o_wv[1]), 32'd0);
    end

    @(negedge clk);
    chk_on = 1'b0;
    $display("%0d/%0d checks passed", n_pass, n_tot);
    $finish;
  end

endmodule

// File: doc/alu_wb.md
ALU_WB -- requirements
Module: alu_wb

Interface
REQ-001 The block SHALL have parameter DEPTH, default 2, meaning the number of buffered writeback entries; legal values are 2, 4 and 8.
REQ-002 The block SHALL have port clk, input, 1 bit: the single clock; every state element samples on its rising edge.
REQ-003 The block SHALL have port rst_n, input, 1 bit: reset, asynchronous assert, active-low.
REQ-004 The block SHALL have port in_valid, input, 1 bit: an ALU result is offered.
REQ-005 The block SHALL have port in_ready, output, 1 bit: the buffer can accept an entry.
REQ-006 The block SHALL have port in_result, input, 16 bits: the ALU result word.
REQ-007 The block SHALL have ports in_carry and in_overflow, input, 1 bit each: the ALU carry-out and the signed-overflow flag.
REQ-008 The block SHALL have port in_select, input, 1 bit: 1 means a logic-unit result, 0 means an arithmetic-unit result.
REQ-009 The block SHALL have port in_dest, input, 3 bits: the destination register index.
REQ-010 The block SHALL have port wb_valid, output, 1 bit: a writeback is presented.
REQ-011 The block SHALL have port wb_ready, input, 1 bit: the register file accepts the writeback.
REQ-012 The block SHALL have ports wb_addr (output, 3 bits) and wb_data (output, 16 bits): the register index and data to write.
REQ-013 The block SHALL have port flags, output, 4 bits, ordered {N,Z,C,V}: the committed status flags.

Function
REQ-014 The block SHALL be an in-order FIFO of DEPTH entries; each entry holds {result, carry, overflow, select, dest}.
REQ-015 A push SHALL occur on a clock edge where in_valid=1 and in_ready=1; a pop SHALL occur on a clock edge where wb_valid=1 and wb_ready=1.
REQ-016 in_ready SHALL equal (count < DEPTH) and SHALL depend only on registered state.
REQ-017 wb_valid SHALL equal (count != 0); wb_addr and wb_data SHALL present the head entry, and SHALL read 0 when the FIFO is empty.
REQ-018 Latency SHALL be one cycle: an entry pushed at edge k appears on wb_* after edge k.
REQ-019 When the FIFO is neither empty nor full, a simultaneous push and pop SHALL leave count unchanged and advance both pointers.
REQ-020 When the FIFO is full, in_ready SHALL be 0; a pop in that cycle SHALL raise in_ready on the next cycle, with no same-cycle pass-through.
REQ-021 When the FIFO is empty, a push SHALL NOT bypass to wb_* in the same cycle.
REQ-022 The read and write pointers SHALL be log2(DEPTH) bits wide and SHALL wrap modulo DEPTH; count SHALL be log2(DEPTH)+1 bits wide.
REQ-023 The flags SHALL update only on a pop (commit order), and SHALL be computed from the popped entry as follows:
- N = result[15];
- Z = (result == 0);
- C and V = the entry's carry and overflow when select=0; C and V hold their previous values when select=1.
REQ-024 Holding in_valid while in_ready=0 SHALL NOT cause a push; holding wb_ready while wb_valid=0 SHALL NOT cause a pop.

Reset
REQ-025 Asserting rst_n=0 SHALL immediately clear count, both pointers and flags to 0; therefore in_ready=1, wb_valid=0, wb_addr=0 and wb_data=0.
REQ-026 A reset asserted mid-operation SHALL discard all buffered entries; no pop SHALL occur for discarded entries.
REQ-027 FIFO storage SHALL need no reset, because it is never observed while empty.

Configuration
REQ-028 Macro STICKY_OVF_EN, when defined, SHALL add:
- input clr_sticky (1 bit);
- output sticky_v (1 bit), which is set by any pop with select=0 and overflow=1, cleared by clr_sticky=1, and reset to 0.
REQ-029 When a set and a clear of sticky_v coincide, sticky_v SHALL become 1 (set wins).
REQ-030 Without STICKY_OVF_EN, the ports clr_sticky and sticky_v and their logic SHALL be absent; all other behaviour SHALL be identical.

Verification
REQ-031 Push {result 0x0000, carry 1, overflow 0, select 0, dest 3} with wb_ready=1 -> next cycle wb_valid=1, wb_addr=3, wb_data=0x0000; after the pop, flags=4'b0110.
REQ-032 Push {0x8000, select 1}, then pop -> flags N=1, Z=0, C and V unchanged from the prior value.
REQ-033 DEPTH=2, wb_ready=0, push 3 entries back-to-back -> in_ready=0 after the second push; the third entry is held; releasing wb_ready drains entries 1 and 2 in order, then accepts entry 3.
REQ-034 DEPTH=4, 10 continuous pushes and pops with wb_ready=1 -> pointers wrap, wb_data follows input order, count stays at 1.
REQ-035 Fill with 2 entries, then pulse rst_n low -> wb_valid=0 and flags=0 immediately; the bench receives no writeback of the stale entries.
REQ-036 With STICKY_OVF_EN defined: pop an entry with overflow=1 and select=0 -> sticky_v=1; it persists across later non-overflow pops; clr_sticky together with a new overflow pop -> sticky_v=1.
